// File: rtl/serial_digit_adder_if.sv
// Operand/result handshake bundle for serial_digit_adder.
// The master side drives operands and takes results; the slave side is the adder.
// Optional macro SERIAL_ADDER_SUB_EN adds the 'sub' operand-mode signal.
interface serial_digit_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             busy;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, s, co, busy
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, s, co, busy
  );
endinterface

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per
// clock, through one registered carry. Valid/ready handshake on both sides.
// Optional macro SERIAL_ADDER_SUB_EN: adds a 'sub' input that turns the
// operation into a - b (b inverted, carry-in forced to 1, co=1 means no borrow).
module serial_digit_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic                clk,
  input logic                rst,
  serial_digit_adder_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  // Reject parameter sets the digit-serial datapath cannot handle
  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("serial_digit_adder: WIDTH must be >= 2");
    end
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
      $error("serial_digit_adder: DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [DIGIT:0]         digit_sum;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [WIDTH-1:0]       sum_next;
  logic [WIDTH-1:0]       b_load;
  logic                   carry_load;

  // One digit of the add, and the sum register after the new digit enters at the MSB end
  always_comb begin
    digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    sum_cat   = {digit_sum[DIGIT-1:0], sum_sh};
    sum_next  = sum_cat[WIDTH+DIGIT-1:DIGIT];
  end

  // Operand B and initial carry as loaded at accept; subtraction inverts B and forces carry-in
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load     = bus.sub ? ~bus.b : bus.b;
    carry_load = bus.sub ? 1'b1 : bus.ci;
`else
    b_load     = bus.b;
    carry_load = bus.ci;
`endif
  end

  // Control FSM and datapath registers; the result is captured only on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      carry       <= 1'b0;
      count       <= '0;
      s_q         <= '0;
      co_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.a;
            b_sh       <= b_load;
            carry      <= carry_load;
            sum_sh     <= '0;
            count      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          sum_sh <= sum_next;
          carry  <= digit_sum[DIGIT];
          if (count == LAST_STEP) begin
            count       <= '0;
            s_q         <= sum_next;
            co_q        <= digit_sum[DIGIT];
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.s         = s_q;
  assign bus.co        = co_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench for serial_digit_adder: three instances (8/1, 4/2, 8/8) checked
// against a plain-arithmetic reference {co,s} = a + b + ci.
module tb_serial_digit_adder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_digit_adder_if #(.WIDTH(8)) b1  ();
  serial_digit_adder_if #(.WIDTH(4)) b4  ();
  serial_digit_adder_if #(.WIDTH(8)) b88 ();

  serial_digit_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (.clk(clk), .rst(rst), .bus(b1));
  serial_digit_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (.clk(clk), .rst(rst), .bus(b4));
  serial_digit_adder #(.WIDTH(8), .DIGIT(8)) u_w8d8 (.clk(clk), .rst(rst), .bus(b88));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One transaction on the 8-bit, 1-bit-digit instance, optionally holding the
  // result under backpressure for 'hold' cycles while pulsing in_valid
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic ci,
                               input logic sub, input int hold);
    logic [8:0] want;
    int lat;
    if (sub) want = {(a >= b), 8'(a - b)};
    else     want = 9'(a) + 9'(b) + 9'(ci);
    @(negedge clk);
    checkOutput("w8d1_idle_ready", 32'(b1.in_ready), 1);
    b1.a = a; b1.b = b; b1.ci = ci;
`ifdef SERIAL_ADDER_SUB_EN
    b1.sub = sub;
`endif
    b1.in_valid = 1'b1;
    @(negedge clk);
    b1.in_valid = 1'b0;
    b1.a = 8'($urandom); b1.b = 8'($urandom);
    checkOutput("w8d1_run_busy_ready", {30'd0, b1.busy, b1.in_ready}, 32'h2);
    lat = 0;
    while (!b1.out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("w8d1_latency", lat, 8);
    for (int h = 0; h < hold; h++) begin
      b1.in_valid = (h % 2 == 0);
      b1.a = 8'($urandom); b1.b = 8'($urandom); b1.ci = 1'($urandom);
      @(negedge clk);
      checkOutput("bp_s_stable", 32'(b1.s), 32'(want[7:0]));
      checkOutput("bp_co_stable", 32'(b1.co), 32'(want[8]));
      checkOutput("bp_in_ready", 32'(b1.in_ready), 0);
      checkOutput("bp_out_valid", 32'(b1.out_valid), 1);
    end
    b1.in_valid = 1'b0;
    checkOutput("w8d1_sum", 32'(b1.s), 32'(want[7:0]));
    checkOutput("w8d1_co", 32'(b1.co), 32'(want[8]));
    b1.out_ready = 1'b1;
    @(negedge clk);
    b1.out_ready = 1'b0;
    checkOutput("w8d1_post_ready", 32'(b1.in_ready), 1);
    checkOutput("w8d1_idle_keep_s", 32'(b1.s), 32'(want[7:0]));
  endtask

  // One transaction on the 4-bit, 2-bit-digit instance
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [4:0] want;
    int lat;
    want = 5'(a) + 5'(b) + 5'(ci);
    @(negedge clk);
    b4.a = a; b4.b = b; b4.ci = ci; b4.in_valid = 1'b1;
    @(negedge clk);
    b4.in_valid = 1'b0;
    lat = 0;
    while (!b4.out_valid && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("w4d2_latency", lat, 2);
    checkOutput("w4d2_sum", {27'd0, b4.co, b4.s}, 32'(want));
    b4.out_ready = 1'b1;
    @(negedge clk);
    b4.out_ready = 1'b0;
  endtask

  // One transaction on the single-step 8-bit instance
  task automatic op88(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] want;
    int lat;
    want = 9'(a) + 9'(b) + 9'(ci);
    @(negedge clk);
    b88.a = a; b88.b = b; b88.ci = ci; b88.in_valid = 1'b1;
    @(negedge clk);
    b88.in_valid = 1'b0;
    lat = 0;
    while (!b88.out_valid && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("w8d8_latency", lat, 1);
    checkOutput("w8d8_sum", {23'd0, b88.co, b88.s}, 32'(want));
    b88.out_ready = 1'b1;
    @(negedge clk);
    b88.out_ready = 1'b0;
  endtask

  initial begin
    int seen_valid;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    b1.in_valid = 0;  b1.out_ready = 0;  b1.a = 0;  b1.b = 0;  b1.ci = 0;
    b4.in_valid = 0;  b4.out_ready = 0;  b4.a = 0;  b4.b = 0;  b4.ci = 0;
    b88.in_valid = 0; b88.out_ready = 0; b88.a = 0; b88.b = 0; b88.ci = 0;
`ifdef SERIAL_ADDER_SUB_EN
    b1.sub = 0; b4.sub = 0; b88.sub = 0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(b1.in_ready), 1);
    checkOutput("rst_out_valid", 32'(b1.out_valid), 0);
    checkOutput("rst_busy", 32'(b1.busy), 0);
    checkOutput("rst_s_co", {23'd0, b1.co, b1.s}, 0);
    checkOutput("rst_w4_in_ready", 32'(b4.in_ready), 1);
    rst = 1'b0;

    $display("[TB] directed FF+01 on 8/1");
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 0);

    $display("[TB] random ops on 8/1");
    for (int i = 0; i < 30; i++)
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 0);

    $display("[TB] backpressure on 8/1");
    applyStimulus(8'h5A, 8'hC3, 1'b1, 1'b0, 5);
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    $display("[TB] subtraction on 8/1");
    applyStimulus(8'h05, 8'h07, 1'b0, 1'b1, 0);
    applyStimulus(8'h07, 8'h05, 1'b1, 1'b1, 0);
    for (int i = 0; i < 10; i++)
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 0);
`endif

    $display("[TB] reset mid-run on 8/1");
    applyStimulus(8'h3C, 8'h42, 1'b1, 1'b0, 0);
    @(negedge clk);
    b1.a = 8'h77; b1.b = 8'h11; b1.ci = 1'b0; b1.in_valid = 1'b1;
    @(negedge clk);
    b1.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 32'(b1.in_ready), 1);
    checkOutput("midrst_out_valid", 32'(b1.out_valid), 0);
    checkOutput("midrst_busy", 32'(b1.busy), 0);
    checkOutput("midrst_s_co", {23'd0, b1.co, b1.s}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b1.out_valid) seen_valid++;
    end
    checkOutput("midrst_no_valid", seen_valid, 0);
    applyStimulus(8'h80, 8'h7F, 1'b1, 1'b0, 0);

    $display("[TB] exhaustive sweep on 4/2");
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      op4(v[3:0], v[7:4], v[8]);
    end

    $display("[TB] single-step 8/8");
    op88(8'h80, 8'h80, 1'b1);
    for (int i = 0; i < 20; i++)
      op88(8'($urandom), 8'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
